myled_axi_lite_slave: RTL and testbench

//  AXI4-Lite responder for the myled controller: four 32-bit registers at offsets 0x0..0xC
//  are accessed by the PS or master VIP; LED pins are driven from them. It sits between the

---
 rtl/myled_pkg.sv | 38 +++
 rtl/myled_blinker.sv | 39 +++
 rtl/myled_axi_lite_slave.sv | 197 +++++++++++++++++++
 tb/tb_myled_axi_lite_slave.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/myled_pkg.sv
// Shared register map, CTRL bit positions and FSM state types for the myled block.
// No logic of its own; the byte-strobe merge helper is purely combinational.
// No flow control lives here; see the slave for handshake behaviour.
package myled_pkg;

  // Register index as selected by address bits [3:2]
  localparam logic [1:0] REG_LED_DATA = 2'd0;
  localparam logic [1:0] REG_CTRL     = 2'd1;
  localparam logic [1:0] REG_PERIOD   = 2'd2;
  localparam logic [1:0] REG_SCRATCH  = 2'd3;

  // CTRL register bits
  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_BLINK_BIT = 1;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  // Merge a 32-bit write into an existing value under byte enables
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/myled_blinker.sv
// Half-period counter producing the blink phase used to gate the LED pattern.
// Phase updates one cycle after the counter reaches period-1 (every cycle for period 0/1).
// No handshake: restart or leaving blink mode forces count 0 and phase 1 on the next edge.
module myled_blinker (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        en_i,
  input  logic [31:0] period_i,
  input  logic        restart_i,
  output logic        phase_o
);
  import myled_pkg::*;

  logic [31:0] cnt_q;
  logic        phase_q;
  logic        wrap;

  // Periods of 0 and 1 both mean "toggle every cycle"
  assign wrap = (period_i <= 32'd1) || (cnt_q == period_i - 32'd1);

  // Count cycles within the half-period and flip the phase on wrap
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      cnt_q   <= 32'd0;
      phase_q <= 1'b1;
    end else if (!en_i || restart_i) begin
      cnt_q   <= 32'd0;
      phase_q <= 1'b1;
    end else if (wrap) begin
      cnt_q   <= 32'd0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_q + 32'd1;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/myled_axi_lite_slave.sv
// AXI4-Lite register slave for the LED controller: four RW registers driving led_o.
// Write response one edge after both AW and W are held; read data one edge after AR.
// AW/W ready drop per channel on accept until BREADY; ARREADY stays low while RVALID waits for RREADY.
module myled_axi_lite_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int LED_WIDTH          = 8
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [LED_WIDTH-1:0]            led_o
);
  import myled_pkg::*;

  // Write channel state
  w_state_t                          wstate_q;
  logic                              awready_q, wready_q, bvalid_q;
  logic                              aw_got_q, w_got_q;
  logic [1:0]                        aw_idx_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]     wdata_q;
  logic [C_S_AXI_DATA_WIDTH/8-1:0]   wstrb_q;

  // Read channel state
  r_state_t                          rstate_q;
  logic                              arready_q, rvalid_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]     rdata_q;

  // Register file and LED drive
  logic [C_S_AXI_DATA_WIDTH-1:0]     regs_q [4];
  logic [LED_WIDTH-1:0]              led_q;

  // Commit path
  logic                              aw_hs, w_hs, ar_hs;
  logic                              wr_en;
  logic [1:0]                        wr_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0]     wr_dat;
  logic [C_S_AXI_DATA_WIDTH/8-1:0]   wr_strb;
  logic                              blink_restart;
  logic                              blink_en;
  logic                              phase;
  logic [C_S_AXI_DATA_WIDTH-1:0]     ctrl;

  // Protection bits and sub-word address bits carry no meaning here
  logic unused_sigs;
  assign unused_sigs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Select address/data from either this cycle's handshake or the held copy
  always_comb begin
    aw_hs   = S_AXI_AWVALID && awready_q;
    w_hs    = S_AXI_WVALID && wready_q;
    ar_hs   = S_AXI_ARVALID && arready_q;
    wr_idx  = aw_hs ? S_AXI_AWADDR[3:2] : aw_idx_q;
    wr_dat  = w_hs ? S_AXI_WDATA : wdata_q;
    wr_strb = w_hs ? S_AXI_WSTRB : wstrb_q;
    wr_en   = (wstate_q == W_IDLE) && (aw_got_q || aw_hs) && (w_got_q || w_hs);
    blink_restart = wr_en && ((wr_idx == REG_CTRL) || (wr_idx == REG_PERIOD));
  end

  // Write FSM: collect AW and W in any order, then hold the response until BREADY
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      aw_idx_q  <= 2'd0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      case (wstate_q)
        W_IDLE: begin
          if (aw_hs) begin
            awready_q <= 1'b0;
            aw_got_q  <= 1'b1;
            aw_idx_q  <= S_AXI_AWADDR[3:2];
          end
          if (w_hs) begin
            wready_q <= 1'b0;
            w_got_q  <= 1'b1;
            wdata_q  <= S_AXI_WDATA;
            wstrb_q  <= S_AXI_WSTRB;
          end
          if (wr_en) begin
            bvalid_q <= 1'b1;
            wstate_q <= W_RESP;
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            wstate_q  <= W_IDLE;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  // Register file: byte-enabled update on the commit edge
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[wr_idx] <= apply_wstrb(regs_q[wr_idx], wr_dat, wr_strb);
    end
  end

  // Read FSM: capture data on AR accept (pre-write value on a colliding commit), hold until RREADY
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          if (ar_hs) begin
            rdata_q   <= regs_q[S_AXI_ARADDR[3:2]];
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            rstate_q  <= R_DATA;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            rstate_q  <= R_IDLE;
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  assign ctrl     = regs_q[REG_CTRL];
  assign blink_en = ctrl[CTRL_EN_BIT] && ctrl[CTRL_BLINK_BIT];

  myled_blinker u_blinker (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .en_i      (blink_en),
    .period_i  (regs_q[REG_PERIOD]),
    .restart_i (blink_restart),
    .phase_o   (phase)
  );

  // LED mux: off, steady pattern, or pattern gated by blink phase
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      led_q <= '0;
    end else if (!ctrl[CTRL_EN_BIT]) begin
      led_q <= '0;
    end else if (!ctrl[CTRL_BLINK_BIT] || phase) begin
      led_q <= regs_q[REG_LED_DATA][LED_WIDTH-1:0];
    end else begin
      led_q <= '0;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign led_o         = led_q;

endmodule

// File: tb/tb_myled_axi_lite_slave.sv
// Directed bench for the LED AXI4-Lite slave with a cycle-level register/LED model.
// Stimulus changes on the falling edge; the model compare runs 2ns after each rising edge.
// Handshake waits are bounded; an expired bound counts as a failed check.
module tb_myled_axi_lite_slave;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [3:0]  S_AXI_AWADDR = '0;
  logic [2:0]  S_AXI_AWPROT = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b0;
  logic [3:0]  S_AXI_ARADDR = '0;
  logic [2:0]  S_AXI_ARPROT = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b0;
  logic [7:0]  led_o;

  myled_axi_lite_slave #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (4),
    .LED_WIDTH          (8)
  ) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .led_o         (led_o)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_errors = 0;
  int edge_n = 0;

  // Pending writes: which rising edge commits them
  typedef struct {
    int          e;
    int          idx;
    logic [31:0] d;
    logic [3:0]  s;
  } wr_t;
  wr_t pend[$];

  // Model state: register contents, edge at which the current blink run started, last phase
  logic [31:0] m_regs [4];
  int          s_edge = 0;
  bit          phase_prev = 1'b1;

  always @(posedge ACLK) edge_n <= edge_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Model compare: LED must equal the pattern implied by the previous cycle's registers and blink phase,
  // where phase is "even number of whole half-periods since the blink run started"
  logic [31:0] c_ctrl;
  bit          c_blink_ok, c_restart;
  int          c_hp;
  logic [7:0]  c_exp_led;
  always @(posedge ACLK) begin
    #2;
    if (ARESET) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      pend.delete();
      s_edge = edge_n;
      phase_prev = 1'b1;
      chk("led_in_reset", 32'(led_o), 32'd0);
    end else begin
      c_ctrl     = m_regs[1];
      c_blink_ok = c_ctrl[0] && c_ctrl[1];
      c_hp       = (m_regs[2] <= 32'd1) ? 1 : int'(m_regs[2]);
      if (!c_ctrl[0])                     c_exp_led = 8'h00;
      else if (!c_ctrl[1] || phase_prev)  c_exp_led = m_regs[0][7:0];
      else                                c_exp_led = 8'h00;
      chk("led_model", 32'(led_o), 32'(c_exp_led));
      chk("bresp_model", 32'(S_AXI_BRESP), 32'd0);
      chk("rresp_model", 32'(S_AXI_RRESP), 32'd0);
      c_restart = 1'b0;
      while (pend.size() > 0 && pend[0].e <= edge_n) begin
        m_regs[pend[0].idx] = merge(m_regs[pend[0].idx], pend[0].d, pend[0].s);
        if (pend[0].idx == 1 || pend[0].idx == 2) c_restart = 1'b1;
        void'(pend.pop_front());
      end
      if (!c_blink_ok || c_restart) s_edge = edge_n;
      phase_prev = (((edge_n - s_edge) / c_hp) % 2) == 0;
    end
  end

  // Write transaction; called and returns on a falling edge
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_off, input int w_off, input int b_hold);
    bit  aw_done, w_done, hs_aw, hs_w;
    int  t;
    wr_t w;
    aw_done = 0; w_done = 0; t = 0;
    while (!(aw_done && w_done)) begin
      if (t > 20) begin
        chk("wr_accept_timeout", 32'd0, 32'd1);
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        return;
      end
      chk("wr_bvalid_before_commit", 32'(S_AXI_BVALID), 32'd0);
      if (aw_done) chk("wr_awready_low_after_accept", 32'(S_AXI_AWREADY), 32'd0);
      if (w_done)  chk("wr_wready_low_after_accept", 32'(S_AXI_WREADY), 32'd0);
      if (!aw_done && t >= aw_off) begin S_AXI_AWVALID = 1'b1; S_AXI_AWADDR = addr; end
      if (!w_done && t >= w_off) begin S_AXI_WVALID = 1'b1; S_AXI_WDATA = data; S_AXI_WSTRB = strb; end
      hs_aw = S_AXI_AWVALID && S_AXI_AWREADY;
      hs_w  = S_AXI_WVALID && S_AXI_WREADY;
      if ((aw_done || hs_aw) && (w_done || hs_w)) begin
        w.e = edge_n + 1; w.idx = int'(addr[3:2]); w.d = data; w.s = strb;
        pend.push_back(w);
      end
      @(posedge ACLK);
      aw_done = aw_done | hs_aw;
      w_done  = w_done | hs_w;
      @(negedge ACLK);
      if (hs_aw) S_AXI_AWVALID = 1'b0;
      if (hs_w)  S_AXI_WVALID  = 1'b0;
      t++;
    end
    chk("wr_bvalid", 32'(S_AXI_BVALID), 32'd1);
    chk("wr_bresp", 32'(S_AXI_BRESP), 32'd0);
    for (int i = 0; i < b_hold; i++) begin
      @(negedge ACLK);
      chk("wr_bvalid_hold", 32'(S_AXI_BVALID), 32'd1);
      chk("wr_awready_hold", 32'(S_AXI_AWREADY), 32'd0);
      chk("wr_wready_hold", 32'(S_AXI_WREADY), 32'd0);
    end
    S_AXI_BREADY = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
    chk("wr_bvalid_cleared", 32'(S_AXI_BVALID), 32'd0);
    chk("wr_awready_back", 32'(S_AXI_AWREADY), 32'd1);
    chk("wr_wready_back", 32'(S_AXI_WREADY), 32'd1);
  endtask

  // Read transaction; called and returns on a falling edge
  task automatic axi_read(input logic [3:0] addr, input int r_hold, output logic [31:0] got);
    logic [31:0] exp;
    int t;
    t = 0;
    S_AXI_ARVALID = 1'b1;
    S_AXI_ARADDR  = addr;
    while (!S_AXI_ARREADY) begin
      if (t > 20) begin
        chk("rd_accept_timeout", 32'd0, 32'd1);
        S_AXI_ARVALID = 1'b0;
        got = '0;
        return;
      end
      @(negedge ACLK);
      t++;
    end
    exp = m_regs[addr[3:2]];
    @(posedge ACLK);
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
    got = S_AXI_RDATA;
    chk("rd_rvalid", 32'(S_AXI_RVALID), 32'd1);
    chk("rd_rdata_model", S_AXI_RDATA, exp);
    chk("rd_arready_low", 32'(S_AXI_ARREADY), 32'd0);
    for (int i = 0; i < r_hold; i++) begin
      @(negedge ACLK);
      chk("rd_rvalid_hold", 32'(S_AXI_RVALID), 32'd1);
      chk("rd_rdata_hold", S_AXI_RDATA, exp);
    end
    S_AXI_RREADY = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    S_AXI_RREADY = 1'b0;
    chk("rd_rvalid_cleared", 32'(S_AXI_RVALID), 32'd0);
    chk("rd_arready_back", 32'(S_AXI_ARREADY), 32'd1);
  endtask

  logic [31:0] rd;
  logic [15:0] pat;
  wr_t         w6;

  initial begin
    foreach (m_regs[i]) m_regs[i] = '0;
    repeat (3) @(negedge ACLK);
    // Reset state
    chk("rst_awready", 32'(S_AXI_AWREADY), 32'd1);
    chk("rst_wready", 32'(S_AXI_WREADY), 32'd1);
    chk("rst_arready", 32'(S_AXI_ARREADY), 32'd1);
    chk("rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
    chk("rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
    chk("rst_rdata", S_AXI_RDATA, 32'd0);
    chk("rst_led", 32'(led_o), 32'd0);
    ARESET = 1'b0;
    @(negedge ACLK);

    // 1: write 1..4, read back (one read uses a non-aligned address)
    axi_write(4'h0, 32'd1, 4'hF, 0, 0, 0);
    axi_write(4'h4, 32'd2, 4'hF, 0, 0, 0);
    axi_write(4'h8, 32'd3, 4'hF, 0, 0, 0);
    axi_write(4'hC, 32'd4, 4'hF, 0, 0, 0);
    axi_read(4'h0, 0, rd); chk("t1_rd_led", rd, 32'd1);
    axi_read(4'h4, 0, rd); chk("t1_rd_ctrl", rd, 32'd2);
    axi_read(4'hA, 0, rd); chk("t1_rd_period_unaligned", rd, 32'd3);
    axi_read(4'hC, 0, rd); chk("t1_rd_scratch", rd, 32'd4);

    // 2: channel ordering
    axi_write(4'hC, 32'h0000_1111, 4'hF, 0, 2, 0);
    axi_read(4'hC, 0, rd); chk("t2_aw_first", rd, 32'h0000_1111);
    axi_write(4'hC, 32'h0000_2222, 4'hF, 2, 0, 0);
    axi_read(4'hC, 0, rd); chk("t2_w_first", rd, 32'h0000_2222);
    axi_write(4'h0, 32'h0000_0033, 4'hF, 0, 0, 0);
    axi_read(4'h0, 0, rd); chk("t2_together", rd, 32'h0000_0033);

    // 3: response backpressure
    axi_write(4'hC, 32'h1122_3344, 4'hF, 0, 0, 5);
    axi_read(4'hC, 5, rd); chk("t3_rd_stalled", rd, 32'h1122_3344);

    // 4: partial strobe
    axi_write(4'hC, 32'hAABB_CCDD, 4'b0010, 0, 0, 0);
    axi_read(4'hC, 0, rd); chk("t4_wstrb", rd, 32'h1122_CC44);

    // Read and write to the same register on the same edge: read sees the old value
    fork
      axi_write(4'hC, 32'h0BAD_F00D, 4'hF, 0, 0, 0);
      begin
        logic [31:0] rd_f;
        axi_read(4'hC, 0, rd_f);
        chk("collide_pre_write", rd_f, 32'h1122_CC44);
      end
    join
    axi_read(4'hC, 0, rd); chk("collide_post_write", rd, 32'h0BAD_F00D);

    // 5: blinking with half-period 4, then steady, then off
    axi_write(4'h0, 32'h0000_00A5, 4'hF, 0, 0, 0);
    axi_write(4'h8, 32'd4, 4'hF, 0, 0, 0);
    axi_write(4'h4, 32'd3, 4'hF, 0, 0, 0);
    pat = 16'b1111_0000_1111_0000;
    for (int j = 0; j < 16; j++) begin
      chk("t5_blink4", 32'(led_o), pat[15-j] ? 32'h0000_00A5 : 32'd0);
      @(negedge ACLK);
    end
    axi_write(4'h4, 32'd1, 4'hF, 0, 0, 0);
    for (int j = 0; j < 4; j++) begin
      chk("t5_steady", 32'(led_o), 32'h0000_00A5);
      @(negedge ACLK);
    end
    axi_write(4'h4, 32'd0, 4'hF, 0, 0, 0);
    for (int j = 0; j < 4; j++) begin
      chk("t5_off", 32'(led_o), 32'd0);
      @(negedge ACLK);
    end

    // PERIOD=0 toggles every cycle
    axi_write(4'h8, 32'd0, 4'hF, 0, 0, 0);
    axi_write(4'h4, 32'd3, 4'hF, 0, 0, 0);
    for (int j = 0; j < 8; j++) begin
      chk("t5_blink0", 32'(led_o), (j % 2 == 0) ? 32'h0000_00A5 : 32'd0);
      @(negedge ACLK);
    end

    // 6: reset while a write response is pending and blinking is active
    S_AXI_AWVALID = 1'b1; S_AXI_AWADDR = 4'hC;
    S_AXI_WVALID = 1'b1;  S_AXI_WDATA = 32'hDEAD_BEEF; S_AXI_WSTRB = 4'hF;
    w6.e = edge_n + 1; w6.idx = 3; w6.d = 32'hDEAD_BEEF; w6.s = 4'hF;
    pend.push_back(w6);
    @(posedge ACLK);
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    chk("t6_bvalid_pending", 32'(S_AXI_BVALID), 32'd1);
    #1 ARESET = 1'b1;
    #1;
    chk("t6_bvalid", 32'(S_AXI_BVALID), 32'd0);
    chk("t6_awready", 32'(S_AXI_AWREADY), 32'd1);
    chk("t6_wready", 32'(S_AXI_WREADY), 32'd1);
    chk("t6_arready", 32'(S_AXI_ARREADY), 32'd1);
    chk("t6_rvalid", 32'(S_AXI_RVALID), 32'd0);
    chk("t6_rdata", S_AXI_RDATA, 32'd0);
    chk("t6_led", 32'(led_o), 32'd0);
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    axi_read(4'h0, 0, rd); chk("t6_rd_led", rd, 32'd0);
    axi_read(4'h4, 0, rd); chk("t6_rd_ctrl", rd, 32'd0);
    axi_read(4'h8, 0, rd); chk("t6_rd_period", rd, 32'd0);
    axi_read(4'hC, 0, rd); chk("t6_rd_scratch", rd, 32'd0);
    repeat (3) @(negedge ACLK);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

endmodule
